im_line_cache: RTL and testbench
================================

// Module: im_line_cache
// PURPOSE
// Instruction-memory responder serving the FETCH stage's IM request port: accepts
// a fetch (enable, addr) and returns pc/instruction/stall/exception one cycle later.
// Holds a direct-mapped line cache; misses are refilled from the external memory
// read bus by a burst FSM while stall is held high toward FETCH.
// PARAMETERS
// LINE_WORDS  4   32-bit words per line (power of two, >=2)
// NUM_LINES   64  cache lines (power of two)
// PORTS
// clk          in   1   clock, all state updates on posedge
// rst_n        in   1   asynchronous, active-low reset
// enable       in   1   fetch request strobe; addr sampled when high
// addr         in   32  fetch byte address
// flush        in   1   invalidate all lines (single-cycle pulse)
// pc_out       out  32  address of the instruction on inst_data
// inst_data    out  32  instruction word for pc_out
// stall        out  1   registered; high while a refill is outstanding
// exception    out  3   0 none, 1 misaligned addr, 2 memory bus error
// mem_req      out  1   refill burst request, held until burst ends
// mem_addr     out  32  line-aligned refill address, stable while mem_req
// mem_rdata    in   32  refill beat data
// mem_rvalid   in   1   refill beat valid (beats in ascending word order)
// mem_err      in   1   error qualifier, sampled only with mem_rvalid
// BEHAVIOUR
// - Reset (async, rst_n=0): pc_out=0, inst_data=0, stall=0, exception=0, mem_req=0,
//   mem_addr=0, all valid bits cleared, FSM=IDLE. Takes effect mid-burst; no stale beat
//   arriving after reset release may write the cache.
// - Outputs are registered; request sampled at edge t is reflected at edge t+1.
// - stall depends only on registers (no combinational path from enable/addr).
// - Address split: offset=addr[1:0], word=next log2(LINE_WORDS) bits, index=next
//   log2(NUM_LINES) bits, tag=remaining upper bits.
// - FSM IDLE: enable=0 -> all outputs hold. enable=1 ->
//   * addr[1:0]!=0: pc_out=addr, inst_data=0, exception=1, no lookup, stay IDLE.
//   * hit (valid & tag match): pc_out=addr, inst_data=word, exception=0, stay IDLE.
//   * miss: pc_out=addr, inst_data=0, exception=0, stall=1, mem_req=1,
//     mem_addr=addr with word/offset bits zeroed, go REFILL.
// - REFILL: enable and addr ignored. Each mem_rvalid beat writes the data array at
//   beat counter position; beat matching requested word is captured.
//   * last beat (count=LINE_WORDS-1), no error: set valid+tag, mem_req=0, go RESP.
//   * beat with mem_err=1: abort, line stays invalid, mem_req=0, go RESP with error.
// - RESP (one cycle): stall=0; inst_data=captured word, exception=0; or on error
//   inst_data=0, exception=2. pc_out unchanged. Next cycle IDLE; enable in RESP
//   cycle is ignored (FETCH has it low since stall was high on prior edge).
// - Miss latency: request edge t, stall high t+1, drops the edge after last beat.
// - flush: clears all valid bits at next edge. If REFILL in progress, burst
//   completes and requested word is still delivered, but the line is NOT validated.
//   flush in same cycle as a hit request: the hit is served (lookup precedes clear).
// - Beat counter width log2(LINE_WORDS), cleared on entry to REFILL.
// - mem_rvalid outside REFILL is ignored.
// TESTING
// 1 Cold miss: enable, addr=0x100 -> next cycle stall=1, mem_addr=0x100; beats
//   0x11,0x22,0x33,0x44 -> RESP: stall=0, pc_out=0x100, inst_data=0x11.
// 2 Hit after fill: enable, addr=0x108 -> next cycle inst_data=0x33, stall=0, no mem_req.
// 3 Misaligned: addr=0x102 -> exception=1, inst_data=0, stall=0, mem_req stays 0.
// 4 Bus error: miss on 0x200, beat 1 with mem_err=1 -> mem_req drops, RESP has
//   exception=2; re-fetch 0x200 misses again (line invalid).
// 5 Flush during refill of 0x300: word delivered, then fetch 0x300 misses again;
//   enable=0 for 5 cycles -> pc_out/inst_data/exception held constant.
// 6 rst_n low mid-burst: outputs zero immediately, mem_req=0; after release,
//   fetch 0x100 misses (all lines invalid).

Source files
------------

// File: rtl/im_line_cache.sv
// Instruction-memory responder for the FETCH stage. A direct-mapped line cache
// answers fetches one cycle after the request. A miss starts a burst refill from
// the external read bus, and stall is held toward FETCH until the burst ends.
module im_line_cache #(
  parameter int LINE_WORDS = 4,
  parameter int NUM_LINES  = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        enable,
  input  logic [31:0] addr,
  input  logic        flush,
  output logic [31:0] pc_out,
  output logic [31:0] inst_data,
  output logic        stall,
  output logic [2:0]  exception,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic [31:0] mem_rdata,
  input  logic        mem_rvalid,
  input  logic        mem_err
);

  localparam int WORD_W  = $clog2(LINE_WORDS);
  localparam int INDEX_W = $clog2(NUM_LINES);
  localparam int TAG_LSB = 2 + WORD_W + INDEX_W;
  localparam int TAG_W   = 32 - TAG_LSB;

  localparam logic [2:0] EXC_NONE  = 3'd0;
  localparam logic [2:0] EXC_ALIGN = 3'd1;
  localparam logic [2:0] EXC_BUS   = 3'd2;

  typedef enum logic [1:0] {IDLE, REFILL, RESP} state_t;
  state_t state;

  logic [NUM_LINES-1:0] valid;
  logic [TAG_W-1:0]     tag_mem  [NUM_LINES];
  logic [31:0]          data_mem [NUM_LINES*LINE_WORDS];

  logic [WORD_W-1:0]  beat_cnt;
  logic [WORD_W-1:0]  req_word;
  logic [INDEX_W-1:0] req_index;
  logic [TAG_W-1:0]   req_tag;
  logic [31:0]        cap_word;
  // A flush seen while the burst is running; the line must then not be validated.
  logic               flush_pend;

  logic [WORD_W-1:0]  a_word;
  logic [INDEX_W-1:0] a_index;
  logic [TAG_W-1:0]   a_tag;
  logic               a_misal;
  logic               a_hit;
  logic [31:0]        hit_word;
  logic [31:0]        line_base;
  logic               beat;
  logic               last_beat;

  assign a_word    = addr[2 +: WORD_W];
  assign a_index   = addr[2 + WORD_W +: INDEX_W];
  assign a_tag     = addr[31:TAG_LSB];
  assign a_misal   = |addr[1:0];
  assign a_hit     = valid[a_index] && (tag_mem[a_index] == a_tag);
  assign hit_word  = data_mem[{a_index, a_word}];
  assign line_base = {addr[31:2+WORD_W], {(2+WORD_W){1'b0}}};
  // Beats are honoured only while a burst is outstanding.
  assign beat      = (state == REFILL) && mem_rvalid;
  assign last_beat = beat && (beat_cnt == WORD_W'(LINE_WORDS - 1));

  // Cache storage: refill beats land at the beat counter position; tag on the final beat
  always_ff @(posedge clk) begin
    if (beat) begin
      data_mem[{req_index, beat_cnt}] <= mem_rdata;
    end
    if (last_beat && !mem_err) begin
      tag_mem[req_index] <= req_tag;
    end
  end

  // Request bookkeeping: remember the missed location and capture its word during the burst
  always_ff @(posedge clk) begin
    if (state == IDLE && enable) begin
      req_word  <= a_word;
      req_index <= a_index;
      req_tag   <= a_tag;
    end
    if (beat && (beat_cnt == req_word)) begin
      cap_word <= mem_rdata;
    end
  end

  // Control FSM with registered outputs toward FETCH and the memory bus
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      pc_out     <= '0;
      inst_data  <= '0;
      stall      <= 1'b0;
      exception  <= EXC_NONE;
      mem_req    <= 1'b0;
      mem_addr   <= '0;
      valid      <= '0;
      beat_cnt   <= '0;
      flush_pend <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (enable) begin
            pc_out <= addr;
            if (a_misal) begin
              inst_data <= '0;
              exception <= EXC_ALIGN;
            end else if (a_hit) begin
              inst_data <= hit_word;
              exception <= EXC_NONE;
            end else begin
              // The burst overwrites this slot, so any resident line is dropped now.
              inst_data      <= '0;
              exception      <= EXC_NONE;
              stall          <= 1'b1;
              mem_req        <= 1'b1;
              mem_addr       <= line_base;
              valid[a_index] <= 1'b0;
              beat_cnt       <= '0;
              flush_pend     <= 1'b0;
              state          <= REFILL;
            end
          end
        end
        REFILL: begin
          flush_pend <= flush_pend | flush;
          if (beat) begin
            if (mem_err) begin
              stall     <= 1'b0;
              mem_req   <= 1'b0;
              inst_data <= '0;
              exception <= EXC_BUS;
              state     <= RESP;
            end else if (last_beat) begin
              stall     <= 1'b0;
              mem_req   <= 1'b0;
              inst_data <= (beat_cnt == req_word) ? mem_rdata : cap_word;
              exception <= EXC_NONE;
              if (!flush_pend && !flush) begin
                valid[req_index] <= 1'b1;
              end
              state     <= RESP;
            end else begin
              beat_cnt <= beat_cnt + 1'b1;
            end
          end
        end
        RESP: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
      // Lookup above uses the pre-flush valid bits; the clear lands last.
      if (flush) begin
        valid <= '0;
      end
    end
  end

endmodule

// File: tb/tb_im_line_cache.sv
// Bench for im_line_cache: directed scenarios followed by randomized fetches,
// checked against a behavioural cache model kept in plain arrays.
module tb_im_line_cache;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        enable;
  logic [31:0] addr;
  logic        flush;
  logic [31:0] pc_out;
  logic [31:0] inst_data;
  logic        stall;
  logic [2:0]  exception;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic [31:0] mem_rdata;
  logic        mem_rvalid;
  logic        mem_err;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: 64 lines of 4 words, direct mapped.
  bit          m_valid [64];
  logic [21:0] m_tag   [64];
  logic [31:0] m_data  [64][4];
  logic [31:0] e_pc;
  logic [31:0] e_inst;
  logic [2:0]  e_exc;

  always #5 clk = ~clk;

  im_line_cache #(.LINE_WORDS(4), .NUM_LINES(64)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .enable     (enable),
    .addr       (addr),
    .flush      (flush),
    .pc_out     (pc_out),
    .inst_data  (inst_data),
    .stall      (stall),
    .exception  (exception),
    .mem_req    (mem_req),
    .mem_addr   (mem_addr),
    .mem_rdata  (mem_rdata),
    .mem_rvalid (mem_rvalid),
    .mem_err    (mem_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic exp_stall, input logic exp_req);
    chk({tag, ".pc"}, pc_out, e_pc);
    chk({tag, ".inst"}, inst_data, e_inst);
    chk({tag, ".exc"}, {29'd0, exception}, {29'd0, e_exc});
    chk({tag, ".stall"}, {31'd0, stall}, {31'd0, exp_stall});
    chk({tag, ".mem_req"}, {31'd0, mem_req}, {31'd0, exp_req});
  endtask

  task automatic m_flush();
    foreach (m_valid[i]) m_valid[i] = 1'b0;
  endtask

  // One fetch transaction, including the refill burst and the response cycle on a miss.
  task automatic fetch(input logic [31:0] a, input bit fl, input int err_beat,
                       input int fl_beat, input bit gaps, input logic [3:0][31:0] beats);
    int unsigned idx;
    int unsigned w;
    logic [31:0] t;
    bit          fp;
    idx = (a >> 4) % 64;
    w   = (a >> 2) % 4;
    t   = a >> 10;
    @(negedge clk);
    enable = 1'b1; addr = a; flush = fl;
    @(negedge clk);
    enable = 1'b0; flush = 1'b0; addr = $urandom;
    e_pc = a;
    if (a % 4 != 0) begin
      e_inst = 32'd0; e_exc = 3'd1;
      if (fl) m_flush();
      chk_out("misal", 1'b0, 1'b0);
    end else if (m_valid[idx] && m_tag[idx] == t[21:0]) begin
      e_inst = m_data[idx][w]; e_exc = 3'd0;
      if (fl) m_flush();
      chk_out("hit", 1'b0, 1'b0);
    end else begin
      m_valid[idx] = 1'b0;
      if (fl) m_flush();
      e_inst = 32'd0; e_exc = 3'd0;
      chk_out("miss", 1'b1, 1'b1);
      chk("miss.mem_addr", mem_addr, a & ~32'hF);
      fp = 1'b0;
      for (int b = 0; b < 4; b++) begin
        if (gaps) begin
          mem_err = 1'($urandom_range(0, 1));
          repeat ($urandom_range(0, 2)) @(negedge clk);
        end
        mem_rvalid = 1'b1; mem_rdata = beats[b];
        mem_err = (b == err_beat); flush = (b == fl_beat);
        @(negedge clk);
        mem_rvalid = 1'b0; mem_err = 1'b0; flush = 1'b0; mem_rdata = $urandom;
        m_data[idx][b] = beats[b];
        if (b == fl_beat) begin
          fp = 1'b1;
          m_flush();
        end
        if (b == err_beat) begin
          e_inst = 32'd0; e_exc = 3'd2;
          chk_out("buserr", 1'b0, 1'b0);
          break;
        end
        if (b == 3) begin
          e_inst = beats[w];
          if (!fp) begin
            m_valid[idx] = 1'b1;
            m_tag[idx]   = t[21:0];
          end
          chk_out("fill", 1'b0, 1'b0);
        end else begin
          chk("refill.stall", {31'd0, stall}, 32'd1);
        end
      end
      // Response cycle: a request and a stray beat here must both be ignored.
      enable = 1'b1; addr = $urandom & ~32'h3; mem_rvalid = 1'b1; mem_rdata = $urandom;
      @(negedge clk);
      enable = 1'b0; mem_rvalid = 1'b0;
      chk_out("resp_hold", 1'b0, 1'b0);
    end
  endtask

  initial begin
    logic [3:0][31:0] bts;
    logic [31:0]      ra;
    int               eb;
    int               fb;
    rst_n = 1'b1; enable = 1'b0; addr = '0; flush = 1'b0;
    mem_rdata = '0; mem_rvalid = 1'b0; mem_err = 1'b0;
    m_flush();
    e_pc = 32'd0; e_inst = 32'd0; e_exc = 3'd0;
    #1 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk_out("reset", 1'b0, 1'b0);
    chk("reset.mem_addr", mem_addr, 32'd0);
    rst_n = 1'b1;

    // Cold miss, then hit on the filled line.
    fetch(32'h100, 1'b0, -1, -1, 1'b0, {32'h44, 32'h33, 32'h22, 32'h11});
    fetch(32'h108, 1'b0, -1, -1, 1'b0, '0);
    // Misaligned fetch.
    fetch(32'h102, 1'b0, -1, -1, 1'b0, '0);
    // Bus error on beat 1, then the same line misses again.
    fetch(32'h200, 1'b0, 1, -1, 1'b0, {32'hA4, 32'hA3, 32'hA2, 32'hA1});
    fetch(32'h200, 1'b0, -1, -1, 1'b0, {32'hB4, 32'hB3, 32'hB2, 32'hB1});
    // Flush during refill: word delivered, line not kept.
    fetch(32'h300, 1'b0, -1, 2, 1'b0, {32'hC4, 32'hC3, 32'hC2, 32'hC1});
    fetch(32'h300, 1'b0, -1, -1, 1'b0, {32'hD4, 32'hD3, 32'hD2, 32'hD1});
    // Idle cycles keep the last response.
    for (int i = 0; i < 5; i++) begin
      addr = $urandom;
      @(negedge clk);
      chk_out("idle_hold", 1'b0, 1'b0);
    end
    // Stray beat while idle is ignored; the hit still returns the filled word.
    mem_rvalid = 1'b1; mem_rdata = 32'hDEADBEEF;
    @(negedge clk);
    mem_rvalid = 1'b0;
    fetch(32'h30C, 1'b0, -1, -1, 1'b0, '0);
    // Flush together with a hit: served, then the line is gone.
    fetch(32'h304, 1'b1, -1, -1, 1'b0, '0);
    fetch(32'h300, 1'b0, -1, -1, 1'b0, {32'hE4, 32'hE3, 32'hE2, 32'hE1});
    fetch(32'h100, 1'b0, -1, -1, 1'b0, {32'h54, 32'h53, 32'h52, 32'h51});

    // Reset in the middle of a burst.
    @(negedge clk);
    enable = 1'b1; addr = 32'h140;
    @(negedge clk);
    enable = 1'b0;
    mem_rvalid = 1'b1; mem_rdata = 32'h77;
    @(negedge clk);
    mem_rvalid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    e_pc = 32'd0; e_inst = 32'd0; e_exc = 3'd0;
    m_flush();
    chk_out("rst_mid", 1'b0, 1'b0);
    chk("rst_mid.mem_addr", mem_addr, 32'd0);
    mem_rvalid = 1'b1; mem_rdata = 32'h88;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    mem_rvalid = 1'b0;
    fetch(32'h100, 1'b0, -1, -1, 1'b0, {32'h64, 32'h63, 32'h62, 32'h61});
    fetch(32'h144, 1'b0, -1, -1, 1'b0, {32'h74, 32'h73, 32'h72, 32'h71});

    // Randomized fetches over a small address set so hits and conflicts occur.
    for (int n = 0; n < 60; n++) begin
      ra = ($urandom_range(0, 1) << 10) | ($urandom_range(0, 3) << 4) | ($urandom_range(0, 3) << 2);
      if ($urandom_range(0, 7) == 0) ra = ra | $urandom_range(1, 3);
      eb = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 3)) : -1;
      fb = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 3)) : -1;
      for (int k = 0; k < 4; k++) bts[k] = $urandom;
      fetch(ra, 1'b0, eb, fb, 1'b1, bts);
      if ($urandom_range(0, 15) == 0) begin
        @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        m_flush();
        chk_out("flush_idle", 1'b0, 1'b0);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
